// File: rtl/qam_demod.sv
// Coherent I/Q QAM demodulator: integrate-and-dump correlators, Gray slicer and bit serializer.
// Define QAM_16_EN for 16-QAM (4 bits/symbol); the default build is 4-QAM (2 bits/symbol).
module qam_demod #(
    parameter int SAMPLES_PER_SYM = 16,
    parameter int ACC_W           = 34,
    parameter int THRESH          = 2**24
) (
    input  logic               inp_clk,
    input  logic               rst,
    input  logic               initialize,
    input  logic               sample_valid,
    input  logic signed [16:0] rx_sample,
    input  logic signed [11:0] cosine,
    input  logic signed [11:0] sine,
    output logic               outputbit,
    output logic               bit_valid,
    output logic               sym_valid,
    output logic [1:0]         i_bits,
    output logic [1:0]         q_bits,
    output logic               overrun
);

    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, SHIFT} state_t;

    localparam int CNT_W = $clog2(SAMPLES_PER_SYM);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_SYM - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = $signed({2'b00, {(ACC_W-1){1'b1}}});
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX;
`ifdef QAM_16_EN
    localparam logic [2:0] BITS_PER_SYM = 3'd4;
    localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);
`else
    localparam logic [2:0] BITS_PER_SYM = 3'd2;
`endif

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         sample_cnt;
    logic signed [ACC_W-1:0]  acc_i, acc_q, acc_i_nxt, acc_q_nxt;
    logic signed [28:0]       prod_i, prod_q;
    logic [3:0]               shreg, load_bits;
    logic [2:0]               bits_left;
    logic [1:0]               dec_i, dec_q;
    logic                     last_sample;

    // Symmetric clamp: the most negative code is never produced, so |acc| always fits.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [28:0]      p
    );
        logic signed [ACC_W:0] s;
        s = $signed({a[ACC_W-1], a}) + (ACC_W+1)'(p);
        if (s > SAT_MAX)
            return SAT_MAX[ACC_W-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[ACC_W-1:0];
        else
            return s[ACC_W-1:0];
    endfunction

    assign prod_i      = rx_sample * cosine;
    assign prod_q      = rx_sample * sine;
    assign last_sample = sample_valid && (sample_cnt == LAST_CNT);

    // The decision cycle dumps the integrators, so a sample arriving then starts from zero.
    assign acc_i_nxt = sat_add((state == DECIDE) ? '0 : acc_i, prod_i);
    assign acc_q_nxt = sat_add((state == DECIDE) ? '0 : acc_q, prod_q);

`ifdef QAM_16_EN
    logic [ACC_W-1:0] mag_i, mag_q;
    assign mag_i     = acc_i[ACC_W-1] ? -acc_i : acc_i;
    assign mag_q     = acc_q[ACC_W-1] ? -acc_q : acc_q;
    // Gray map: sign bit first, then "inner level" bit (-3:00, -1:01, +1:11, +3:10).
    assign dec_i     = {~acc_i[ACC_W-1], mag_i < THRESH_V};
    assign dec_q     = {~acc_q[ACC_W-1], mag_q < THRESH_V};
    assign load_bits = {dec_i, dec_q};
`else
    assign dec_i     = {~acc_i[ACC_W-1], 1'b0};
    assign dec_q     = {~acc_q[ACC_W-1], 1'b0};
    assign load_bits = {dec_i[1], dec_q[1], 2'b00};
`endif

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:   if (sample_valid) state_nxt = last_sample ? DECIDE : ACCUM;
            ACCUM:  if (last_sample)  state_nxt = DECIDE;
            DECIDE: state_nxt = SHIFT;
            SHIFT: begin
                if (last_sample)
                    state_nxt = DECIDE;
                else if (bits_left == 3'd1)
                    state_nxt = ACCUM;
            end
            default: state_nxt = IDLE;
        endcase
        if (initialize)
            state_nxt = IDLE;
    end

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge inp_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            shreg      <= '0;
            bits_left  <= '0;
            outputbit  <= 1'b0;
            bit_valid  <= 1'b0;
            sym_valid  <= 1'b0;
            i_bits     <= '0;
            q_bits     <= '0;
            overrun    <= 1'b0;
        end else if (initialize) begin
            state      <= IDLE;
            sample_cnt <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            shreg      <= '0;
            bits_left  <= '0;
            outputbit  <= 1'b0;
            bit_valid  <= 1'b0;
            sym_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state     <= state_nxt;
            sym_valid <= (state == DECIDE);

            if (sample_valid) begin
                acc_i      <= acc_i_nxt;
                acc_q      <= acc_q_nxt;
                sample_cnt <= last_sample ? '0 : sample_cnt + CNT_W'(1);
            end else if (state == DECIDE) begin
                acc_i <= '0;
                acc_q <= '0;
            end

            if (state == DECIDE) begin
                i_bits    <= dec_i;
                q_bits    <= dec_q;
                shreg     <= load_bits;
                bits_left <= BITS_PER_SYM;
                bit_valid <= 1'b0;
                overrun   <= overrun | (bits_left != 3'd0);
            end else if (state == SHIFT) begin
                outputbit <= shreg[3];
                shreg     <= {shreg[2:0], 1'b0};
                bits_left <= bits_left - 3'd1;
                bit_valid <= 1'b1;
            end else begin
                bit_valid <= 1'b0;
            end
        end
    end

endmodule
